// File: rtl/interrupt_ctrl_block_pkg.sv
// ---------------------------------------------------------------------------
// intc_pkg
// Shared definitions for the interrupt controller in front of the MIPS core:
//   - FSM state encoding (IDLE / ASSERT / SERVICE)
//   - default values for N_IRQ, SYNC_STAGES and ID_W
//   - prio_search(): circular priority search over a request vector,
//     returning the winning index and a found flag
// ---------------------------------------------------------------------------
package intc_pkg;

    localparam int unsigned N_IRQ_DEF       = 8;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned ID_W_DEF        = 4;

    // The search function works on the largest legal source count and is
    // zero-padded for smaller configurations.
    localparam int unsigned MAX_IRQ   = 16;
    localparam int unsigned MAX_IDX_W = 4;
    localparam int unsigned POS_W     = MAX_IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ASSERT  = 2'b01,
        SERVICE = 2'b10
    } intc_state_e;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } prio_result_t;

    // Scan vec starting at 'start', wrapping at n, and return the first set
    // bit. With start = 0 this is plain lowest-index-wins priority.
    function automatic prio_result_t prio_search(
        input logic [MAX_IRQ-1:0]   vec,
        input logic [MAX_IDX_W-1:0] start,
        input int unsigned          n
    );
        prio_result_t res;
        logic [POS_W-1:0] pos;
        res.found = 1'b0;
        res.idx   = {MAX_IDX_W{1'b0}};
        for (int unsigned k = 0; k < MAX_IRQ; k++) begin
            // start < n and k < n, so one subtraction is enough to wrap
            pos = {1'b0, start} + POS_W'(k);
            if (pos >= POS_W'(n)) begin
                pos = pos - POS_W'(n);
            end else begin
                pos = pos;
            end
            if (!res.found && (k < n) && vec[pos[MAX_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = pos[MAX_IDX_W-1:0];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/interrupt_ctrl_block_if.sv
// ---------------------------------------------------------------------------
// interrupt_ctrl_block_if
// Bundles the request, mask, handshake and status signals of the interrupt
// controller.
//   master : the requester / core side (drives irq_src, mask_*, irq_done)
//   slave  : the controller (drives interrupt, irq_id, pending, busy)
// ---------------------------------------------------------------------------
interface interrupt_ctrl_block_if #(
    parameter int unsigned N_IRQ = 8,
    parameter int unsigned ID_W  = 4
);
    logic [N_IRQ-1:0] irq_src;
    logic             mask_we;
    logic [N_IRQ-1:0] mask_wdata;
    logic             irq_done;
    logic             interrupt;
    logic [ID_W-1:0]  irq_id;
    logic [N_IRQ-1:0] pending;
    logic             busy;

    modport master (
        output irq_src, mask_we, mask_wdata, irq_done,
        input  interrupt, irq_id, pending, busy
    );

    modport slave (
        input  irq_src, mask_we, mask_wdata, irq_done,
        output interrupt, irq_id, pending, busy
    );
endinterface

// File: rtl/interrupt_ctrl_block_irq_sync_edge.sv
// ---------------------------------------------------------------------------
// irq_sync_edge
// Synchronises one asynchronous request line through SYNC_STAGES flops and
// flags its rising edge (sync_now & ~sync_prev) for one cycle.
// Ports:
//   clk, reset : system clock, async active-high reset
//   irq_in     : raw asynchronous request
//   edge_out   : one-cycle pulse on a synchronised rising edge
// ---------------------------------------------------------------------------
module irq_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_in,
    output logic edge_out
);
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Synchroniser chain plus the delayed copy used for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], irq_in};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign edge_out = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/interrupt_ctrl_block.sv
// ---------------------------------------------------------------------------
// interrupt_ctrl_block
// Prioritised interrupt controller feeding the MIPS core's interrupt input.
// Rising edges of the synchronised sources are latched into a pending
// register; eligible = pending & mask. When idle the winner is latched into
// irq_id, its pending bit is cleared and a one-cycle interrupt pulse is
// issued; no further pulse is issued until irq_done arrives in SERVICE.
// Ports:
//   clk, reset : system clock, async active-high reset
//   bus        : interrupt_ctrl_block_if.slave (irq_src, mask_we, mask_wdata,
//                irq_done in; interrupt, irq_id, pending, busy out)
// Build option:
//   INTC_PRIO_ROTATE_EN defined   -> round-robin priority via last_served
//   INTC_PRIO_ROTATE_EN undefined -> fixed priority, lowest index wins
// ---------------------------------------------------------------------------
module interrupt_ctrl_block
    import intc_pkg::*;
#(
    parameter int unsigned N_IRQ       = N_IRQ_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned ID_W        = ID_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    interrupt_ctrl_block_if.slave  bus
);
    logic [N_IRQ-1:0]     edge_s;
    logic [N_IRQ-1:0]     mask_r;
    logic [N_IRQ-1:0]     pending_r;
    logic [N_IRQ-1:0]     eligible_s;
    logic [N_IRQ-1:0]     clr_s;
    logic [MAX_IDX_W-1:0] start_s;
    prio_result_t         sel_s;
    logic                 accept_s;
    intc_state_e          state_r;
    logic                 interrupt_r;
    logic                 busy_r;
    logic [ID_W-1:0]      irq_id_r;

    for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk      (clk),
            .reset    (reset),
            .irq_in   (bus.irq_src[i]),
            .edge_out (edge_s[i])
        );
    end

    assign eligible_s = pending_r & mask_r;

`ifdef INTC_PRIO_ROTATE_EN
    logic [MAX_IDX_W-1:0] last_served_r;

    // Search begins just after the last served source, wrapping at N_IRQ
    always_comb begin
        start_s = {MAX_IDX_W{1'b0}};
        if (last_served_r == MAX_IDX_W'(N_IRQ - 1)) begin
            start_s = {MAX_IDX_W{1'b0}};
        end else begin
            start_s = last_served_r + {{(MAX_IDX_W-1){1'b0}}, 1'b1};
        end
    end

    // Remember the source accepted on each IDLE->ASSERT transition
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_served_r <= MAX_IDX_W'(N_IRQ - 1);
        end else if (accept_s) begin
            last_served_r <= sel_s.idx;
        end else begin
            last_served_r <= last_served_r;
        end
    end
`else
    assign start_s = {MAX_IDX_W{1'b0}};
`endif

    assign sel_s    = prio_search(MAX_IRQ'(eligible_s), start_s, N_IRQ);
    assign accept_s = (state_r == IDLE) && sel_s.found;

    // One-hot clear mask for the source being accepted this cycle
    always_comb begin
        clr_s = {N_IRQ{1'b0}};
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (accept_s && (sel_s.idx == MAX_IDX_W'(i))) begin
                clr_s[i] = 1'b1;
            end else begin
                clr_s[i] = 1'b0;
            end
        end
    end

    // Pending register: a new edge wins over a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= {N_IRQ{1'b0}};
        end else begin
            pending_r <= (pending_r & ~clr_s) | edge_s;
        end
    end

    // Software mask; a write is visible to selection the following cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_r <= {N_IRQ{1'b1}};
        end else if (bus.mask_we) begin
            mask_r <= bus.mask_wdata;
        end else begin
            mask_r <= mask_r;
        end
    end

    // Service FSM with registered interrupt pulse, busy flag and irq_id
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            interrupt_r <= 1'b0;
            busy_r      <= 1'b0;
            irq_id_r    <= {ID_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r     <= ASSERT;
                        interrupt_r <= 1'b1;
                        busy_r      <= 1'b1;
                        irq_id_r    <= ID_W'(sel_s.idx);
                    end else begin
                        state_r     <= IDLE;
                        interrupt_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                ASSERT: begin
                    // irq_done here is deliberately dropped, not queued
                    state_r     <= SERVICE;
                    interrupt_r <= 1'b0;
                    busy_r      <= 1'b1;
                end
                SERVICE: begin
                    interrupt_r <= 1'b0;
                    if (bus.irq_done) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= SERVICE;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    interrupt_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.interrupt = interrupt_r;
    assign bus.busy      = busy_r;
    assign bus.irq_id    = irq_id_r;
    assign bus.pending   = pending_r;

endmodule

// File: doc/interrupt_ctrl_block.md
Name: interrupt_ctrl_block

Overview:
- Prioritised interrupt controller directly upstream of the MIPS core; drives the core's `interrupt` input, which feeds the jump-control stage.
- Collects up to N_IRQ asynchronous external requests, synchronises them and latches rising edges into a pending register.
- Applies a software-writable mask, issues one interrupt pulse per serviced request, and blocks further pulses until the handler signals completion.

Parameters:
- N_IRQ, 8, number of external interrupt sources (2..16).
- SYNC_STAGES, 2, synchroniser flops per source (minimum 2).
- ID_W, 4, width of irq_id; must satisfy 2^ID_W >= N_IRQ.

Ports:
- clk  in  1  system clock, shared with the MIPS core.
- reset  in  1  asynchronous, active-high; clears all state.
- irq_src  in  N_IRQ  raw asynchronous request lines, active-high.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  N_IRQ  new mask value; 1 = source enabled.
- irq_done  in  1  one-cycle pulse from the core/handler marking end of service.
- interrupt  out  1  one-cycle pulse to the MIPS core.
- irq_id  out  ID_W  index of the source being serviced; stable from the interrupt pulse until irq_done.
- pending  out  N_IRQ  current pending register, for status readback.
- busy  out  1  high while in ASSERT or SERVICE.

Behaviour:
- Reset values (asynchronous assertion):
  - interrupt=0, irq_id=0, pending=0, busy=0.
  - mask = all ones.
  - Synchroniser and edge flops = 0.
  - FSM = IDLE.
- Synchronisation: each irq_src bit passes through SYNC_STAGES flops. Edge = sync_now & ~sync_prev.
  - Latency from irq_src rising to the pending bit set is SYNC_STAGES+1 cycles.
- Pending: a detected edge sets pending[i]. Edges are counted only once, so a source held high does not retrigger.
  - A pending bit is cleared only when the FSM accepts that source (IDLE to ASSERT).
  - If a new edge and the clear occur for the same bit in the same cycle, the set wins; the bit stays pending.
- Mask: a mask_we write takes effect the next cycle.
  - Masked sources still latch into pending but are not eligible for selection.
  - Unmasking a pending source makes it eligible the cycle after the write.
- Selection: eligible = pending & mask. In fixed-priority mode the lowest index wins.
- FSM states:
  - IDLE: if eligible != 0, latch the winner into irq_id, clear its pending bit, go to ASSERT. Otherwise stay.
  - ASSERT: interrupt=1 for exactly this cycle; go to SERVICE.
  - SERVICE: interrupt=0. On irq_done go to IDLE; the next selection can occur in the cycle after IDLE is re-entered.
- irq_done in IDLE or ASSERT is ignored; it is not queued.
- busy = (state != IDLE).
- Back-to-back requests: minimum spacing between interrupt pulses is 3 cycles (ASSERT, SERVICE, IDLE).
- Mid-operation reset: all pending requests are discarded, interrupt drops immediately, and irq_id returns to 0.
- Ports irq_src[i] with i >= N_IRQ do not exist; irq_id values >= N_IRQ are never produced.

Optional Feature:
- Macro: INTC_PRIO_ROTATE_EN.
- Defined: round-robin priority. A last_served register (reset value N_IRQ-1) is kept; the search starts at last_served+1 modulo N_IRQ and wraps. last_served updates on each IDLE to ASSERT transition.
- Undefined: fixed priority, lowest index wins; no last_served register is synthesised.

Decomposition:
- Package intc_pkg holds:
  - the FSM state enum (IDLE, ASSERT, SERVICE, 2-bit encoding);
  - default constants for N_IRQ, SYNC_STAGES and ID_W;
  - a priority-search function returning the index and a found flag.
- One sub-module, irq_sync_edge: a per-source synchroniser plus rising-edge detector, instantiated N_IRQ times via generate.

Test Plan:
- Reset release, then pulse irq_src[3] high for 5 cycles → pending[3]=1 after 3 cycles; interrupt pulses for 1 cycle with irq_id=3; pending[3]=0; busy=1 until irq_done.
- irq_src[5] and irq_src[2] rise in the same cycle (fixed priority) → first pulse irq_id=2; after irq_done, second pulse irq_id=5, 3 cycles later.
- mask_wdata=0xFB, then irq_src[2] rises → pending[2]=1 with no interrupt. Write mask 0xFF → pulse with irq_id=2 on the second cycle after the write.
- irq_src[1] held high for 50 cycles across two irq_done pulses → exactly one interrupt pulse.
- Assert reset while in SERVICE with pending=0x10 → interrupt, busy, pending and irq_id are all 0 immediately; no pulse follows after release.
- With INTC_PRIO_ROTATE_EN, sources 0, 1 and 4 re-triggered continuously → service order 0, 1, 4, 0, 1, 4.
